// File: rtl/thread_sched.sv
// thread_sched: round-robin thread scheduler for the md5 engine.
//
// Walks every thread through one registered thread_state read port, and picks a
// thread whose state is READY and whose core input slot is free. The thread number
// goes to process_bytes over a valid/ack handshake. The thread is then marked BUSY
// through the thread_state write port.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   ts_rd_num         thread_state read address (the scan pointer)
//   ts_rd             state of ts_rd_num, valid one cycle after the address
//   ts_wr_num/ts_wr   thread_state write address/data, strobed by ts_wr_en
//   core_ready        per-slot "input slot free" flags (thread t -> core t/4, slot t%4)
//   sched_valid       grant valid to process_bytes, with sched_thread_num
//   sched_ack         process_bytes accepted the grant
//   err               sticky protocol error (ack without valid, or watchdog)
//
// Optional feature: define THREAD_SCHED_WATCHDOG_EN to add a GRANT watchdog
// (WDT_MSB+1 bits) that sets err when a grant waits too long for its ack.
module thread_sched #(
  parameter int unsigned     N_CORES       = 3,
  parameter int unsigned     N_THREADS     = 4 * N_CORES,
  parameter int unsigned     N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int unsigned     TS_W          = 4,
  parameter logic [TS_W-1:0] ST_READY      = TS_W'(1),
  parameter logic [TS_W-1:0] ST_BUSY       = TS_W'(2),
  parameter int unsigned     WDT_MSB       = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  output logic [N_THREADS_MSB:0] ts_rd_num,
  input  logic [TS_W-1:0]        ts_rd,
  output logic [N_THREADS_MSB:0] ts_wr_num,
  output logic [TS_W-1:0]        ts_wr,
  output logic                   ts_wr_en,
  input  logic [4*N_CORES-1:0]   core_ready,
  output logic                   sched_valid,
  output logic [N_THREADS_MSB:0] sched_thread_num,
  input  logic                   sched_ack,
  output logic                   err
);

  localparam int unsigned TnW = N_THREADS_MSB + 1;
  localparam logic [TnW-1:0] LastThread = TnW'(N_THREADS - 1);

  typedef enum logic [1:0] {StScan, StCheck, StGrant, StWrite} state_e;

  state_e                 state_q;
  logic [TnW-1:0]         p_q;
  logic [TnW-1:0]         p_inc;
  logic [TnW-1:0]         ts_wr_num_q;
  logic [TS_W-1:0]        ts_wr_q;
  logic                   ts_wr_en_q;
  logic                   valid_q;
  logic [TnW-1:0]         thread_q;
  logic [N_THREADS-1:0]   hold_q;
  logic [N_THREADS-1:0]   hold_d;
  logic                   err_q;
  logic                   wdt_fire;
  logic                   grant_ok;

  // Explicit wrap so a non-power-of-two thread count never overshoots.
  assign p_inc = (p_q == LastThread) ? '0 : p_q + 1'b1;

  assign grant_ok = (ts_rd == ST_READY) && core_ready[p_q] && !hold_q[p_q];

  // A slot stays held from its grant until the core shows it busy (ready low).
  // The set is applied after the clear so a same-slot set/clear leaves it set.
  always_comb begin
    hold_d = hold_q & core_ready[N_THREADS-1:0];
    if (state_q == StGrant && sched_ack) begin
      hold_d[p_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StScan;
      p_q         <= '0;
      ts_wr_num_q <= '0;
      ts_wr_q     <= '0;
      ts_wr_en_q  <= 1'b0;
      valid_q     <= 1'b0;
      thread_q    <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      hold_q <= hold_d;
      if ((sched_ack && !valid_q) || wdt_fire) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        StScan: begin
          state_q <= StCheck;
        end
        StCheck: begin
          if (grant_ok) begin
            thread_q <= p_q;
            valid_q  <= 1'b1;
            state_q  <= StGrant;
          end else begin
            p_q     <= p_inc;
            state_q <= StScan;
          end
        end
        StGrant: begin
          // The grant is never withdrawn, even if core_ready[p] drops meanwhile.
          if (sched_ack) begin
            valid_q     <= 1'b0;
            ts_wr_en_q  <= 1'b1;
            ts_wr_num_q <= p_q;
            ts_wr_q     <= ST_BUSY;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          ts_wr_en_q <= 1'b0;
          p_q        <= p_inc;
          state_q    <= StScan;
        end
        default: begin
          state_q <= StScan;
        end
      endcase
    end
  end

`ifdef THREAD_SCHED_WATCHDOG_EN
  localparam logic [WDT_MSB:0] WdtLast = {{WDT_MSB{1'b1}}, 1'b0};

  logic [WDT_MSB:0] wdt_q;

  // Counter saturates at all-ones; err fires on the edge where it gets there.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdt_q <= '0;
    end else if (state_q == StGrant) begin
      if (wdt_q != '1) begin
        wdt_q <= wdt_q + 1'b1;
      end
    end else begin
      wdt_q <= '0;
    end
  end

  assign wdt_fire = (state_q == StGrant) && (wdt_q == WdtLast);
`else
  logic unused_wdt;
  assign unused_wdt = 1'(WDT_MSB);
  assign wdt_fire   = 1'b0;
`endif

  assign ts_rd_num        = p_q;
  assign ts_wr_num        = ts_wr_num_q;
  assign ts_wr            = ts_wr_q;
  assign ts_wr_en         = ts_wr_en_q;
  assign sched_valid      = valid_q;
  assign sched_thread_num = thread_q;
  assign err              = err_q;

endmodule

// File: tb/tb_thread_sched.sv
// Directed testbench for thread_sched (3 cores, 12 threads).
// A small thread_state memory model with a registered read port sits beside the DUT.
// The bench loads states through set_en/set_num/set_val. DUT writes land in the same memory.
module tb_thread_sched;

  localparam int unsigned NCores   = 3;
  localparam int unsigned NThreads = 12;
`ifdef THREAD_SCHED_WATCHDOG_EN
  localparam int unsigned WdtMsb = 3;
`else
  localparam int unsigned WdtMsb = 15;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  ts_rd_num;
  logic [3:0]  ts_rd;
  logic [3:0]  ts_wr_num;
  logic [3:0]  ts_wr;
  logic        ts_wr_en;
  logic [11:0] core_ready;
  logic        sched_valid;
  logic [3:0]  sched_thread_num;
  logic        sched_ack;
  logic        err;

  logic [3:0]  mem [NThreads];
  logic        mem_clr;
  logic        set_en;
  logic [3:0]  set_num;
  logic [3:0]  set_val;

  int checks = 0;
  int errors = 0;

  thread_sched #(
    .N_CORES (NCores),
    .WDT_MSB (WdtMsb)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .ts_rd_num        (ts_rd_num),
    .ts_rd            (ts_rd),
    .ts_wr_num        (ts_wr_num),
    .ts_wr            (ts_wr),
    .ts_wr_en         (ts_wr_en),
    .core_ready       (core_ready),
    .sched_valid      (sched_valid),
    .sched_thread_num (sched_thread_num),
    .sched_ack        (sched_ack),
    .err              (err)
  );

  always #5 CLK = ~CLK;

  // thread_state model: registered read; bench loads override a same-cycle DUT write.
  always @(posedge CLK) begin
    ts_rd <= mem[ts_rd_num];
    if (mem_clr) begin
      for (int i = 0; i < NThreads; i++) mem[i] <= 4'h0;
    end else begin
      if (ts_wr_en) mem[ts_wr_num] <= ts_wr;
      if (set_en) mem[set_num] <= set_val;
    end
  end

  task automatic set_state(input logic [3:0] num, input logic [3:0] val);
    set_en  = 1'b1;
    set_num = num;
    set_val = val;
    @(negedge CLK);
    set_en  = 1'b0;
  endtask

  // Returns at the first negedge where sched_valid is seen, or after budget cycles.
  task automatic wait_grant(input int budget, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge CLK);
      if (sched_valid === 1'b1) begin
        found  = 1'b1;
        cycles = i;
      end
    end
  endtask

  // Called at a negedge with the grant visible; returns at the WRITE-cycle negedge.
  task automatic ack_once();
    sched_ack = 1'b1;
    @(negedge CLK);
    sched_ack = 1'b0;
  endtask

  task automatic test_reset();
    int bad_seq;
    int bad_valid;
    int bad_wr;
    int first_bad;
    bad_seq = 0; bad_valid = 0; bad_wr = 0; first_bad = -1;
    RST = 1'b1; mem_clr = 1'b1; core_ready = 12'hFFF;
    repeat (3) @(negedge CLK);
    checks++;
    if ({sched_valid, ts_wr_en, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: valid/wr_en/err=%b required 000", {sched_valid, ts_wr_en, err});
    end
    checks++;
    if ({ts_rd_num, ts_wr_num, ts_wr, sched_thread_num} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: rd_num/wr_num/wr/thread=%h required 0000",
               {ts_rd_num, ts_wr_num, ts_wr, sched_thread_num});
    end
    RST = 1'b0; mem_clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (ts_rd_num !== 4'((k / 2) % NThreads)) begin
        bad_seq++;
        if (first_bad < 0) first_bad = k;
      end
      if (sched_valid !== 1'b0) bad_valid++;
      if (ts_wr_en !== 1'b0) bad_wr++;
      @(negedge CLK);
    end
    checks++;
    if (bad_seq != 0) begin
      errors++;
      $display("FAIL scan_seq: %0d cycles off (first at cycle %0d) required 0", bad_seq, first_bad);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++;
      $display("FAIL idle_valid: sched_valid high %0d cycles required 0", bad_valid);
    end
    checks++;
    if (bad_wr != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL idle_wr_err: wr pulses=%0d err=%b required 0 and 0", bad_wr, err);
    end
  endtask

  task automatic test_grant_basic();
    bit found;
    int cyc;
    int unstable;
    unstable = 0;
    set_state(4'd5, 4'h1);
    wait_grant(40, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd5) begin
      errors++;
      $display("FAIL grant5: found=%b thread=%0d required 1 and 5", found, sched_thread_num);
    end
    repeat (2) begin
      @(negedge CLK);
      if (sched_valid !== 1'b1 || sched_thread_num !== 4'd5) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL grant5_hold: %0d unstable cycles required 0", unstable);
    end
    ack_once();
    checks++;
    if ({sched_valid, ts_wr_en, ts_wr_num, ts_wr} !== {1'b0, 1'b1, 4'd5, 4'h2}) begin
      errors++;
      $display("FAIL write5: valid=%b wr_en=%b wr_num=%0d wr=%0d required 0 1 5 2",
               sched_valid, ts_wr_en, ts_wr_num, ts_wr);
    end
    @(negedge CLK);
    checks++;
    if (ts_wr_en !== 1'b0 || ts_rd_num !== 4'd6) begin
      errors++;
      $display("FAIL after5: wr_en=%b rd_num=%0d required 0 and 6", ts_wr_en, ts_rd_num);
    end
  endtask

  task automatic test_fairness();
    bit found;
    int cyc;
    int seen;
    seen = 0;
    core_ready = 12'h000;
    set_state(4'd2, 4'h1);
    set_state(4'd9, 4'h1);
    for (int i = 0; i < 30 && ts_rd_num !== 4'd0; i++) @(negedge CLK);
    core_ready = 12'hFFF;
    wait_grant(12, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd2) begin
      errors++;
      $display("FAIL fair_first: found=%b thread=%0d required 1 and 2", found, sched_thread_num);
    end
    ack_once();
    set_state(4'd2, 4'h1);  // thread 2 stays READY
    wait_grant(30, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd9) begin
      errors++;
      $display("FAIL fair_second: found=%b thread=%0d required 1 and 9", found, sched_thread_num);
    end
    ack_once();
    repeat (40) begin
      @(negedge CLK);
      if (sched_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL hold_block: valid high %0d cycles with slot held required 0", seen);
    end
    core_ready = 12'hFFB;
    @(negedge CLK);
    core_ready = 12'hFFF;
    wait_grant(2 * NThreads + 2, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd2) begin
      errors++;
      $display("FAIL hold_release: found=%b thread=%0d required 1 and 2", found, sched_thread_num);
    end
    ack_once();
  endtask

  task automatic test_slot_wait();
    bit found;
    int cyc;
    int seen;
    seen = 0;
    core_ready = 12'h7FF;
    set_state(4'd11, 4'h1);
    repeat (50) begin
      @(negedge CLK);
      if (sched_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL slot_busy: valid high %0d cycles while slot busy required 0", seen);
    end
    core_ready = 12'hFFF;
    wait_grant(2 * NThreads, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd11) begin
      errors++;
      $display("FAIL grant11: found=%b thread=%0d after %0d cycles required 1 and 11",
               found, sched_thread_num, cyc);
    end
    ack_once();
    @(negedge CLK);
    checks++;
    if (ts_rd_num !== 4'd0) begin
      errors++;
      $display("FAIL wrap: rd_num=%0d required 0", ts_rd_num);
    end
  endtask

`ifdef THREAD_SCHED_WATCHDOG_EN
  task automatic test_watchdog();
    bit found;
    int cyc;
    set_state(4'd4, 4'h1);
    wait_grant(40, found, cyc);
    repeat (14) @(negedge CLK);
    checks++;
    if (found !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL wdt_early: found=%b err=%b required 1 and 0", found, err);
    end
    @(negedge CLK);
    checks++;
    if (err !== 1'b1 || sched_valid !== 1'b1) begin
      errors++;
      $display("FAIL wdt_fire: err=%b valid=%b required 1 and 1", err, sched_valid);
    end
    ack_once();
  endtask
`endif

  task automatic test_reset_mid_grant();
    bit found;
    int cyc;
    int bad;
    bad = 0;
    core_ready = 12'hFFF;
    set_state(4'd3, 4'h1);
    wait_grant(40, found, cyc);
    checks++;
    if (found !== 1'b1 || sched_thread_num !== 4'd3) begin
      errors++;
      $display("FAIL grant3: found=%b thread=%0d required 1 and 3", found, sched_thread_num);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (sched_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_drop: valid=%b required 0", sched_valid);
    end
    core_ready = 12'h000;
    @(negedge CLK);
    if (ts_wr_en !== 1'b0) bad++;
    RST = 1'b0;
    checks++;
    if (ts_rd_num !== 4'd0 || mem[3] !== 4'h1) begin
      errors++;
      $display("FAIL rst_restart: rd_num=%0d state3=%0d required 0 and 1", ts_rd_num, mem[3]);
    end
    repeat (2) begin
      @(negedge CLK);
      if (ts_wr_en !== 1'b0 || sched_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || ts_rd_num !== 4'd1) begin
      errors++;
      $display("FAIL rst_no_write: bad cycles=%0d rd_num=%0d required 0 and 1", bad, ts_rd_num);
    end
  endtask

  task automatic test_err_idle();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%b required 0", err);
    end
    sched_ack = 1'b1;
    @(negedge CLK);
    sched_ack = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err=%b required 1", err);
    end
    repeat (5) @(negedge CLK);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  initial begin
    RST = 1'b1; mem_clr = 1'b1; set_en = 1'b0; set_num = '0; set_val = '0;
    sched_ack = 1'b0; core_ready = 12'hFFF;
    test_reset();
    test_grant_basic();
    test_fairness();
    test_slot_wait();
`ifdef THREAD_SCHED_WATCHDOG_EN
    test_watchdog();
`endif
    test_reset_mid_grant();
    test_err_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t required finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/thread_sched.md
Name: thread_sched

Overview:
- Round-robin scheduler that chooses which thread the process_bytes sequencer serves next.
- Scans thread_state through one dedicated read/write channel. Picks a thread only when its state is READY and its core input slot (core_ready bit) is free.
- Hands the thread number to process_bytes with a valid/ack handshake, then marks the thread BUSY.
- Sits between thread_state, the cores' ready vector and process_bytes inside the md5 engine.

Parameters:
- N_CORES, 3, number of md5 cores.
- N_THREADS, 4*N_CORES, thread count; thread t maps to core t/4, slot t%4.
- N_THREADS_MSB, `MSB(N_THREADS-1), MSB of thread number.
- TS_W, 4, width of a thread state word.
- ST_READY, 4'h1, state value meaning "input data ready for a core".
- ST_BUSY, 4'h2, state value written on grant.
- WDT_MSB, 15, watchdog counter MSB (optional feature only).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- ts_rd_num  out  N_THREADS_MSB+1  thread_state read address.
- ts_rd  in  TS_W  state of ts_rd_num, valid 1 cycle after address (registered read).
- ts_wr_num  out  N_THREADS_MSB+1  thread_state write address.
- ts_wr  out  TS_W  state to write.
- ts_wr_en  out  1  write strobe.
- core_ready  in  4*N_CORES  per-slot "slot free" flags from cores.
- sched_valid  out  1  grant valid to process_bytes.
- sched_thread_num  out  N_THREADS_MSB+1  granted thread.
- sched_ack  in  1  process_bytes accepted grant.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, RST=1): FSM=SCAN, scan pointer p=0, ts_rd_num=0, ts_wr_en=0, ts_wr=0, ts_wr_num=0, sched_valid=0, sched_thread_num=0, slot hold mask=0, err=0. A mid-grant reset drops sched_valid immediately; no thread_state write is issued.
- FSM states:
  - SCAN: drive ts_rd_num=p; go to CHECK.
  - CHECK: ts_rd is valid.
    - If ts_rd==ST_READY, core_ready[p] is 1 and hold[p] is 0: latch sched_thread_num=p, assert sched_valid, go to GRANT.
    - Otherwise p=p+1 (wrapping N_THREADS-1 to 0), go to SCAN.
    - Cost: 2 cycles per thread examined.
  - GRANT: hold sched_valid and sched_thread_num stable until sched_ack.
    - On the ack cycle: sched_valid=0 next cycle, set hold[p], go to WRITE.
    - core_ready[p] dropping during GRANT does not withdraw the grant.
  - WRITE: pulse ts_wr_en=1 for one cycle with ts_wr_num=p and ts_wr=ST_BUSY. Then p=p+1 (wrapped), go to SCAN.
- hold[s] blocks re-grant of slot s. It clears on any cycle where core_ready[s]==0, and this takes priority over a set in the same cycle only if the set targets another slot. A set and a clear on the same slot leave it set.
- Wrap-around: with N_THREADS not a power of two, p never exceeds N_THREADS-1.
- Fairness: after a grant, scanning resumes at p+1, so no thread is granted twice while another READY thread with a free slot waits a full rotation.
- err is set and stays set (until RST) on sched_ack while sched_valid==0.
- Minimum grant-to-grant spacing: 4 cycles (GRANT with same-cycle ack, WRITE, SCAN, CHECK).

Optional Feature:
- Macro THREAD_SCHED_WATCHDOG_EN.
- Defined:
  - A WDT_MSB+1-bit counter runs while in GRANT and clears on leaving GRANT.
  - When the counter reaches all-ones, err is set (sticky).
  - The grant stays asserted after the watchdog fires.
- Undefined: no counter; err reflects the ack-without-valid violation only.

Test Plan:
1. Reset with 12 threads all at state 0 and core_ready=12'hFFF -> sched_valid stays 0 for 100 cycles; ts_rd_num cycles 0..11, 0...; err=0.
2. Thread 5 set to ST_READY, core_ready[5]=1, ack returned 2 cycles after sched_valid -> sched_thread_num=5; one ts_wr_en pulse with ts_wr_num=5, ts_wr=2; the next ts_rd_num is 6.
3. Threads 2 and 9 READY; grant 2 but keep thread 2 READY with core_ready[2] held at 1 -> next grant is 9. Thread 2 is not re-granted until core_ready[2] has gone 0 and returned to 1.
4. Thread 11 READY, core_ready[11]=0 for 50 cycles, then 1 -> no grant while 0; grant for 11 within 2*N_THREADS cycles after the rise; p wraps 11 to 0 afterward.
5. Assert RST during GRANT for thread 3 -> sched_valid=0 asynchronously, no ts_wr_en, scan restarts at 0. Separately, sched_ack pulsed while idle -> err=1 and remains 1.
6. With THREAD_SCHED_WATCHDOG_EN and WDT_MSB=3, withhold ack -> err rises exactly 15 cycles after GRANT entry; sched_valid stays 1.
